// File: rtl/adder_sum_accumulator.sv
// Frame accumulator behind the pipelined 16-bit adder.
// Sums N_SAMPLES beats (or fewer on flush) and holds each total until taken.
module adder_sum_accumulator #(
  parameter  int DATA_WIDTH = 16,
  parameter  int N_SAMPLES  = 9,
  parameter  int ACC_WIDTH  = 20,
  localparam int CNT_WIDTH  = $clog2(N_SAMPLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_ovf
);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf_acc;

  logic                 accept;
  logic                 last;
  logic                 close;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 ovf_nxt;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);

  assign accept  = in_valid & in_ready;
  assign sum_ext = {1'b0, acc} + (ACC_WIDTH + 1)'(in_data);

  // Next-frame values include this cycle's beat so a close captures it.
  assign acc_nxt = accept ? sum_ext[ACC_WIDTH-1:0] : acc;
  assign cnt_nxt = accept ? cnt + CNT_WIDTH'(1) : cnt;
  assign ovf_nxt = ovf_acc | (accept & sum_ext[ACC_WIDTH]);

  assign last  = accept & (cnt == CNT_WIDTH'(N_SAMPLES - 1));
  assign close = in_ready &
                 (last | (flush & ((cnt != '0) | accept)));

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == ACC):  if (close)     state_nxt = HOLD;
      (state == HOLD): if (out_ready) state_nxt = ACC;
      default:         state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (close) begin
      out_sum   <= acc_nxt;
      out_count <= cnt_nxt;
      out_ovf   <= ovf_nxt;
      acc       <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
    end else if (accept) begin
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      ovf_acc <= ovf_nxt;
    end
  end

endmodule
